// File: rtl/nibble_serial_adder_pkg.sv
// nibble_adder_pkg: shared definitions for the nibble-serial adder.
//   NIBBLE        - width of one slice step (4 bits)
//   state_t       - FSM state type, with ST_IDLE / ST_RUN / ST_DONE constants
//   nibble_count  - number of nibble steps (N) for a given operand width
package nibble_adder_pkg;

  localparam int NIBBLE = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  function automatic int nibble_count(input int width);
    return width / NIBBLE;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// nibble_serial_adder_if: start/done handshake and operand/result bus.
//   start, a, b, c_in      - request side (driven by master)
//   busy, done, sum, c_out - response side (driven by slave)
//   ovf                    - signed overflow, only when OVERFLOW_FLAG_EN is defined
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
`ifdef OVERFLOW_FLAG_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b, c_in,
`ifdef OVERFLOW_FLAG_EN
    input  ovf,
`endif
    input  busy, done, sum, c_out
  );

  modport slave (
    input  start, a, b, c_in,
`ifdef OVERFLOW_FLAG_EN
    output ovf,
`endif
    output busy, done, sum, c_out
  );

endinterface

// File: rtl/four_ripple_carry_adder.sv
// four_ripple_carry_adder: purely combinational 4-bit ripple-carry adder slice.
//   a, b    - 4-bit addends
//   c_zero  - carry into bit 0
//   sum     - 4-bit sum
//   c_four  - carry out of bit 3
module four_ripple_carry_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_zero,
  output logic [3:0] sum,
  output logic       c_four
);

  // Ripple the carry bit by bit through four full adders.
  always_comb begin
    logic carry_s;
    carry_s = c_zero;
    sum     = 4'd0;
    for (int i = 0; i < 4; i++) begin
      sum[i]  = a[i] ^ b[i] ^ carry_s;
      carry_s = (a[i] & b[i]) | (carry_s & (a[i] ^ b[i]));
    end
    c_four = carry_s;
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit adder that processes one nibble per clock,
// LSB first, through a single four_ripple_carry_adder slice.
//   clk, rst_n  - rising-edge clock, asynchronous active-low reset
//   bus (slave) - start/a/b/c_in request, busy/done/sum/c_out response
// Optional feature: define OVERFLOW_FLAG_EN to add the registered signed
// overflow output bus.ovf.
// Latency is N = WIDTH/4 cycles from the accepting edge to done; a start in
// the done cycle is accepted immediately for back-to-back operation.
module nibble_serial_adder
  import nibble_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  nibble_serial_adder_if.slave bus
);

  localparam int N    = nibble_count(WIDTH);
  localparam int IDXW = (N > 2) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  if ((WIDTH % NIBBLE) != 0 || WIDTH < 8) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 8");
  end

  state_t           state_r, next_state_s;
  logic [IDXW-1:0]  idx_r;
  logic [WIDTH-1:0] op_a_r, op_b_r, sum_r;
  logic             carry_r, c_out_r, busy_r, done_r;
  logic             accept_s, last_s;
  logic [3:0]       slice_sum_s;
  logic             slice_c_four_s;

  assign accept_s = bus.start && (state_r == ST_IDLE || state_r == ST_DONE);
  assign last_s   = (state_r == ST_RUN) && (idx_r == LAST_IDX);

  four_ripple_carry_adder u_slice (
    .a      (op_a_r[3:0]),
    .b      (op_b_r[3:0]),
    .c_zero (carry_r),
    .sum    (slice_sum_s),
    .c_four (slice_c_four_s)
  );

  // Next-state decode; start during RUN is deliberately ignored.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) next_state_s = ST_RUN;
        else          next_state_s = ST_IDLE;
      end
      ST_RUN: begin
        if (last_s) next_state_s = ST_DONE;
        else        next_state_s = ST_RUN;
      end
      ST_DONE: begin
        if (accept_s) next_state_s = ST_RUN;
        else          next_state_s = ST_IDLE;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // FSM, nibble index, operand/sum shift registers and carry chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      idx_r   <= '0;
      op_a_r  <= '0;
      op_b_r  <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      c_out_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      // busy/done are registered copies of the state being entered.
      busy_r  <= (next_state_s == ST_RUN);
      done_r  <= (next_state_s == ST_DONE);
      if (accept_s) begin
        op_a_r  <= bus.a;
        op_b_r  <= bus.b;
        carry_r <= bus.c_in;
        idx_r   <= '0;
      end else if (state_r == ST_RUN) begin
        op_a_r  <= op_a_r >> NIBBLE;
        op_b_r  <= op_b_r >> NIBBLE;
        // Right-shift accumulation: after N steps nibble 0 sits at the bottom.
        sum_r   <= {slice_sum_s, sum_r[WIDTH-1:NIBBLE]};
        carry_r <= slice_c_four_s;
        idx_r   <= last_s ? '0 : idx_r + IDXW'(1'b1);
        if (last_s) begin
          c_out_r <= slice_c_four_s;
        end else begin
          c_out_r <= c_out_r;
        end
      end else begin
        op_a_r  <= op_a_r;
        op_b_r  <= op_b_r;
        carry_r <= carry_r;
        idx_r   <= idx_r;
      end
    end
  end

`ifdef OVERFLOW_FLAG_EN
  logic ovf_r;

  // Signed overflow: carry into the MSB (recovered from the MSB sum bit) XOR carry out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if (last_s && !accept_s) begin
      ovf_r <= (op_a_r[3] ^ op_b_r[3] ^ slice_sum_s[3]) ^ slice_c_four_s;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  assign bus.ovf = ovf_r;
`endif

  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.sum   = sum_r;
  assign bus.c_out = c_out_r;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16): directed cases from
// the design notes followed by randomized operations, all checked against a
// plain-arithmetic reference model.
module tb_nibble_serial_adder;

  localparam int WIDTH = 16;
  localparam int N     = WIDTH / 4;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;

  nibble_serial_adder_if #(.WIDTH(WIDTH)) bus ();

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Drive one request (caller is positioned just after a rising edge), then
  // check the busy window, exact latency and the result against the model.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                        input bit disturb);
    logic [16:0] full;
    int          ssum;
    full = {1'b0, ta} + {1'b0, tb_v} + {16'd0, tc};
    ssum = int'($signed(ta)) + int'($signed(tb_v)) + int'(tc);
    bus.start = 1'b1;
    bus.a     = ta;
    bus.b     = tb_v;
    bus.c_in  = tc;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("busy_after_accept", {31'd0, bus.busy}, 32'd1);
    for (int k = 1; k < N; k++) begin
      if (disturb && k == 1) begin
        bus.start = 1'b1;
        bus.a     = ~ta;
        bus.b     = ta ^ 16'h5A5A;
        bus.c_in  = ~tc;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      check("busy_in_run", {31'd0, bus.busy}, 32'd1);
      check("no_early_done", {31'd0, bus.done}, 32'd0);
    end
    bus.start = 1'b0;
    @(posedge clk); #1;
    check("done_latency", {31'd0, bus.done}, 32'd1);
    check("busy_in_done", {31'd0, bus.busy}, 32'd0);
    check("sum", {16'd0, bus.sum}, {16'd0, full[15:0]});
    check("c_out", {31'd0, bus.c_out}, {31'd0, full[16]});
`ifdef OVERFLOW_FLAG_EN
    check("ovf", {31'd0, bus.ovf}, {31'd0, (ssum > 32767 || ssum < -32768)});
`else
    if (ssum > 32767) check("ovf_model_unused", 32'd0, {31'd0, bus.done ^ 1'b1});
`endif
  endtask

  // One idle cycle after done: result must hold, done must drop.
  task automatic idle_hold(input logic [15:0] exp_sum, input logic exp_c);
    bus.start = 1'b0;
    @(posedge clk); #1;
    check("hold_done_low", {31'd0, bus.done}, 32'd0);
    check("hold_sum", {16'd0, bus.sum}, {16'd0, exp_sum});
    check("hold_c_out", {31'd0, bus.c_out}, {31'd0, exp_c});
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic        rc;
    logic [16:0] rfull;
    pass_cnt  = 0;
    total_cnt = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = 16'd0;
    bus.b     = 16'd0;
    bus.c_in  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_sum", {16'd0, bus.sum}, 32'd0);
    check("rst_c_out", {31'd0, bus.c_out}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases.
    run_op(16'h0001, 16'h0002, 1'b0, 1'b0);
    idle_hold(16'h0003, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    idle_hold(16'h0000, 1'b1);
    run_op(16'h00FF, 16'h0000, 1'b1, 1'b0);
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0);   // back-to-back from the done cycle
    idle_hold(16'h5555, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    idle_hold(16'h8000, 1'b0);
    run_op(16'h8000, 16'h8000, 1'b1, 1'b1);   // start in RUN ignored
    idle_hold(16'h0001, 1'b1);

    // Reset in the middle of an operation.
    bus.start = 1'b1;
    bus.a     = 16'hFFFF;
    bus.b     = 16'hFFFF;
    bus.c_in  = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check("midrst_done", {31'd0, bus.done}, 32'd0);
    check("midrst_sum", {16'd0, bus.sum}, 32'd0);
    check("midrst_c_out", {31'd0, bus.c_out}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_idle", {31'd0, bus.busy}, 32'd0);
    run_op(16'hABCD, 16'h1111, 1'b1, 1'b0);

    // Randomized operations, mixing back-to-back and gapped starts.
    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      run_op(ra, rb, rc, 1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) begin
        rfull = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
        idle_hold(rfull[15:0], rfull[16]);
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
